// File: rtl/fifo_sync_ctrl_if.sv
// Producer/consumer bundle for fifo_sync_ctrl: write side, read side and status flags.
// master = the user logic driving requests, slave = the FIFO itself.
interface fifo_sync_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO: storage array, wrapping pointers, separate occupancy counter,
// programmable almost-full/almost-empty, overflow/underflow pulses, standard or FWFT read.
module fifo_sync_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input logic             clk,
    input logic             rst_n,
    fifo_sync_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic full_w;
    logic empty_w;
    logic wr_acc;
    logic rd_acc;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Guards make a full FIFO take only the read and an empty FIFO take only the write.
    always_comb begin
        wr_acc      = bus.wr_en & ~full_w;
        rd_acc      = bus.rd_en & ~empty_w;
        wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d  = bus.wr_en & full_w;
        underflow_d = bus.rd_en & empty_w;
        count_d     = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.din;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head of queue is shown combinationally; rd_en acts as a pop.
            assign bus.dout     = mem[rd_ptr_q];
            assign bus.rd_valid = ~empty_w;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q     <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= mem[rd_ptr_q];
                    end
                end
            end

            assign bus.dout     = dout_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Scoreboard bench for fifo_sync_ctrl: a standard-read instance and an FWFT instance.
module tb_fifo_sync_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_sync_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
    fifo_sync_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

    fifo_sync_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    fifo_sync_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] sb_q    [$];
    logic [DW-1:0] sb1_q   [$];
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_flags();
        int sz = model_q.size();
        check("count",        32'(bus0.count),        32'(sz));
        check("full",         32'(bus0.full),         32'(sz == DEPTH));
        check("empty",        32'(bus0.empty),        32'(sz == 0));
        check("almost_full",  32'(bus0.almost_full),  32'(sz >= AF));
        check("almost_empty", 32'(bus0.almost_empty), 32'(sz <= AE));
        check("overflow",     32'(bus0.overflow),     32'(exp_ovf));
        check("underflow",    32'(bus0.underflow),    32'(exp_unf));
    endtask

    // One clock of stimulus on the standard-read instance; expected read data goes to sb_q.
    task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rd);
        int sz = model_q.size();
        bus0.wr_en = wr;
        bus0.din   = d;
        bus0.rd_en = rd;
        exp_ovf = wr && (sz == DEPTH);
        exp_unf = rd && (sz == 0);
        if (rd && sz > 0) sb_q.push_back(model_q.pop_front());
        if (wr && sz < DEPTH) model_q.push_back(d);
        @(posedge clk);
        #1;
        bus0.wr_en = 1'b0;
        bus0.rd_en = 1'b0;
        $display("txn wr=%0b din=%02h rd=%0b -> count=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
                 wr, d, rd, bus0.count, bus0.full, bus0.empty, bus0.overflow, bus0.underflow);
        check_flags();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_q.delete();
        sb_q.delete();
        sb1_q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // FWFT instance: one clock, pop pushes the head we expect to have been shown.
    task automatic cycle1(input logic wr, input logic [DW-1:0] d, input logic rd, input logic [DW-1:0] exp_head);
        bus1.wr_en = wr;
        bus1.din   = d;
        bus1.rd_en = rd;
        if (rd) sb1_q.push_back(exp_head);
        @(posedge clk);
        #1;
        bus1.wr_en = 1'b0;
        bus1.rd_en = 1'b0;
        $display("txn1 wr=%0b din=%02h rd=%0b -> dout=%02h rd_valid=%0b count=%0d",
                 wr, d, rd, bus1.dout, bus1.rd_valid, bus1.count);
    endtask

    // Monitor: every rd_valid from the standard instance must match the next expected word.
    always @(negedge clk) begin
        if (rst_n && bus0.rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got rd_valid=1 dout=%02h, required no read data", bus0.dout);
            end else begin
                check("rd_data", 32'(bus0.dout), 32'(sb_q.pop_front()));
            end
        end
    end

    // Monitor for FWFT: a pop while valid consumes the head currently on dout.
    always @(negedge clk) begin
        if (rst_n && bus1.rd_en === 1'b1 && bus1.rd_valid === 1'b1) begin
            if (sb1_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fwft_unexpected_pop: got dout=%02h, required no pop", bus1.dout);
            end else begin
                check("fwft_head", 32'(bus1.dout), 32'(sb1_q.pop_front()));
            end
        end
    end

    initial begin
        bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.din = '0;
        bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.din = '0;

        do_reset();
        check_flags();
        check("reset_dout",     32'(bus0.dout),     32'h0);
        check("reset_rd_valid", 32'(bus0.rd_valid), 32'h0);

        // Read while empty after reset
        cycle(1'b0, 8'h00, 1'b1);
        check("unf_dout",     32'(bus0.dout),     32'h0);
        check("unf_rd_valid", 32'(bus0.rd_valid), 32'h0);
        cycle(1'b0, 8'h00, 1'b0);

        // Fill with 0x00..0x0F, then overflow and a simultaneous request while full
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Simultaneous request while empty: write only, read flagged
        cycle(1'b1, 8'h99, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Steady state at count 8 with concurrent traffic wrapping both pointers
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        // Asynchronous reset mid-cycle discards stored words
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        #1;
        check_flags();
        check("rst_rd_valid", 32'(bus0.rd_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h77, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check("sb_after_rst", 32'(sb_q.size()), 32'h0);

        // FWFT instance
        do_reset();
        check("fwft_rst_valid", 32'(bus1.rd_valid), 32'h0);
        cycle1(1'b1, 8'hA5, 1'b0, 8'h00);
        check("fwft_dout",  32'(bus1.dout),     32'hA5);
        check("fwft_valid", 32'(bus1.rd_valid), 32'h1);
        cycle1(1'b1, 8'h3C, 1'b0, 8'h00);
        check("fwft_count2", 32'(bus1.count), 32'h2);
        cycle1(1'b0, 8'h00, 1'b1, 8'hA5);
        check("fwft_next_head", 32'(bus1.dout),     32'h3C);
        check("fwft_valid2",    32'(bus1.rd_valid), 32'h1);
        cycle1(1'b0, 8'h00, 1'b1, 8'h3C);
        check("fwft_empty",       32'(bus1.empty),    32'h1);
        check("fwft_valid_empty", 32'(bus1.rd_valid), 32'h0);
        cycle1(1'b0, 8'h00, 1'b1, 8'h00);
        check("fwft_underflow", 32'(bus1.underflow), 32'h1);
        sb1_q.delete();
        cycle1(1'b0, 8'h00, 1'b0, 8'h00);
        check("fwft_unf_pulse", 32'(bus1.underflow), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
